// File: rtl/valu_seq.sv
// Multi-cycle vector ALU: a VLEN-bit op is processed DPW bits per beat, with tail/illegal handling.
// Optional per-element masking is enabled with the VALU_MASK_EN macro.
module valu_seq #(
    parameter int VLEN = 128,
    parameter int DPW  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [2:0]                i_sew,
    input  logic [5:0]                i_ctrl,
    input  logic [$clog2(VLEN/8):0]   i_vl,
    input  logic [VLEN-1:0]           i_dataa,
    input  logic [VLEN-1:0]           i_datab,
    input  logic [VLEN-1:0]           i_datad,
`ifdef VALU_MASK_EN
    input  logic                      i_vm,
    input  logic [VLEN/8-1:0]         i_mask,
`endif
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [VLEN-1:0]           o_result,
    output logic                      o_err
);
    localparam int BEATS = VLEN / DPW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VLW   = $clog2(VLEN/8) + 1;

    localparam logic [5:0] VADD = 6'b000000, VSUB = 6'b000001, VSLT  = 6'b000010,
                           VSLTU = 6'b000011, VAND = 6'b000100, VOR = 6'b000101,
                           VXOR = 6'b000110, VSLL = 6'b011000, VSRL = 6'b011001,
                           VSRA = 6'b011010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [BW-1:0]      r_beat;
    logic [1:0]         r_sew;
    logic [5:0]         r_ctrl;
    logic [VLW-1:0]     r_vl;
    logic [VLEN-1:0]    r_a, r_b, r_d, r_result;
    logic               r_valid, r_err;
`ifdef VALU_MASK_EN
    logic               r_vm;
    logic [VLEN/8-1:0]  r_mask;
`endif

    // Operands arrive zero-extended to 64 bits; the caller keeps only the low SEW bits.
    function automatic logic [63:0] f_elem(input logic [5:0] ctrl, input logic [1:0] sew,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] as, bs;
        logic [5:0]  sh;
        case (sew)
            2'd0:    begin as = {{56{a[7]}},  a[7:0]};  bs = {{56{b[7]}},  b[7:0]};  sh = {3'b0, b[2:0]}; end
            2'd1:    begin as = {{48{a[15]}}, a[15:0]}; bs = {{48{b[15]}}, b[15:0]}; sh = {2'b0, b[3:0]}; end
            2'd2:    begin as = {{32{a[31]}}, a[31:0]}; bs = {{32{b[31]}}, b[31:0]}; sh = {1'b0, b[4:0]}; end
            default: begin as = a;                      bs = b;                      sh = b[5:0];         end
        endcase
        case (ctrl)
            VADD:    f_elem = a + b;
            VSUB:    f_elem = a - b;
            VSLT:    f_elem = {63'd0, $signed(as) < $signed(bs)};
            VSLTU:   f_elem = {63'd0, a < b};
            VAND:    f_elem = a & b;
            VOR:     f_elem = a | b;
            VXOR:    f_elem = a ^ b;
            VSLL:    f_elem = a << sh;
            VSRL:    f_elem = a >> sh;
            VSRA:    f_elem = $unsigned($signed(as) >>> sh);
            default: f_elem = 64'd0;
        endcase
    endfunction

    logic              w_legal;
    logic [VLW-1:0]    w_vlmax, w_vl_eff;
    logic [DPW-1:0]    w_a, w_b, w_d, w_res;
    logic [3:0][DPW-1:0] w_sl;

    assign w_legal  = (i_sew < 3'd4) &&
                      (i_ctrl inside {VADD, VSUB, VSLT, VSLTU, VAND, VOR, VXOR, VSLL, VSRL, VSRA});
    assign w_vlmax  = VLW'(VLEN/8) >> i_sew[1:0];
    assign w_vl_eff = (i_vl < w_vlmax) ? i_vl : w_vlmax;

    assign w_a = r_a[int'(r_beat)*DPW +: DPW];
    assign w_b = r_b[int'(r_beat)*DPW +: DPW];
    assign w_d = r_d[int'(r_beat)*DPW +: DPW];

    // One lane set per SEW; the latched SEW picks which one feeds the result register.
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int W  = 8 << g;
        localparam int NE = DPW / W;
        for (genvar j = 0; j < NE; j++) begin : g_el
            logic [W-1:0]   w_r;
            logic [VLW-1:0] w_idx;
            logic           w_act;
            assign w_r   = W'(f_elem(r_ctrl, 2'(g), 64'(w_a[j*W +: W]), 64'(w_b[j*W +: W])));
            assign w_idx = VLW'(int'(r_beat)*NE + j);
`ifdef VALU_MASK_EN
            assign w_act = (w_idx < r_vl) && (r_vm || r_mask[w_idx[VLW-2:0]]);
`else
            assign w_act = (w_idx < r_vl);
`endif
            assign w_sl[g][j*W +: W] = w_act ? w_r : w_d[j*W +: W];
        end
    end

    assign w_res    = w_sl[r_sew];
    assign o_ready  = (r_state == IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_err    = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_sew    <= '0;
            r_ctrl   <= '0;
            r_vl     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
`ifdef VALU_MASK_EN
            r_vm     <= 1'b1;
            r_mask   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (i_valid) begin
                    r_sew  <= i_sew[1:0];
                    r_ctrl <= i_ctrl;
                    r_vl   <= w_vl_eff;
                    r_a    <= i_dataa;
                    r_b    <= i_datab;
                    r_d    <= i_datad;
`ifdef VALU_MASK_EN
                    r_vm   <= i_vm;
                    r_mask <= i_mask;
`endif
                    if (!w_legal || i_vl == '0) begin
                        r_result <= i_datad;
                        r_err    <= !w_legal;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_err   <= 1'b0;
                        r_beat  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[int'(r_beat)*DPW +: DPW] <= w_res;
                    if (r_beat == BW'(BEATS-1)) begin
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: if (i_ready) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_valu_seq.sv
// Directed bench for valu_seq (VLEN=128, DPW=64) with hand-computed expected vectors.
module tb_valu_seq;
    logic         i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic         o_ready, o_valid, o_err;
    logic [2:0]   i_sew = '0;
    logic [5:0]   i_ctrl = '0;
    logic [4:0]   i_vl = '0;
    logic [127:0] i_dataa = '0, i_datab = '0, i_datad = '0, o_result;
    int           n_tests = 0, n_fail = 0, lat;
    logic [127:0] held;

    valu_seq #(.VLEN(128), .DPW(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sew(i_sew), .i_ctrl(i_ctrl), .i_vl(i_vl),
        .i_dataa(i_dataa), .i_datab(i_datab), .i_datad(i_datad),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sew, input logic [5:0] ctrl, input logic [4:0] vl,
                         input logic [127:0] a, input logic [127:0] b, input logic [127:0] d);
        @(negedge i_clk);
        i_sew = sew; i_ctrl = ctrl; i_vl = vl;
        i_dataa = a; i_datab = b; i_datad = d;
        i_valid = 1'b1;
    endtask

    // lat = edges after the accept edge before o_valid is seen (0 = visible right after accept).
    task automatic wait_valid(output int l);
        l = 0;
        while (!o_valid && l < 20) begin
            @(posedge i_clk); #1;
            l++;
        end
    endtask

    task automatic run_op(input logic [2:0] sew, input logic [5:0] ctrl, input logic [4:0] vl,
                          input logic [127:0] a, input logic [127:0] b, input logic [127:0] d,
                          output int l);
        drive(sew, ctrl, vl, a, b, d);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wait_valid(l);
    endtask

    task automatic take;
        @(negedge i_clk); i_ready = 1'b1;
        @(posedge i_clk); #1; i_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_err",   128'(o_err),   128'd0);
        chk("rst_res",   o_result,      128'd0);
        chk("rst_ready", 128'(o_ready), 128'd1);
        @(negedge i_clk); i_rst = 1'b0;

        run_op(3'd0, 6'b000000, 5'd16, {16{8'hFF}}, {16{8'h01}}, {16{8'h5A}}, lat);
        chk("add8_res", o_result, 128'd0);
        chk("add8_lat", 128'(lat), 128'd2);
        chk("add8_err", 128'(o_err), 128'd0);
        take();
        chk("idle_after", 128'(o_ready), 128'd1);

        run_op(3'd2, 6'b000010, 5'd4, 128'hFFFFFFFF, 128'h1, 128'd0, lat);
        chk("slt32", o_result, 128'h1);
        take();
        run_op(3'd2, 6'b000011, 5'd4, 128'hFFFFFFFF, 128'h1, 128'd0, lat);
        chk("sltu32", o_result, 128'h0);
        take();

        run_op(3'd1, 6'b011010, 5'd8, 128'h8000, 128'h0011, 128'd0, lat);
        chk("sra16", o_result, 128'hC000);
        take();
        run_op(3'd1, 6'b011000, 5'd8, 128'h0001, 128'h0010, 128'd0, lat);
        chk("sll16", o_result, 128'h0001);
        take();
        run_op(3'd0, 6'b011001, 5'd16, {16{8'h80}}, {16{8'h0F}}, 128'd0, lat);
        chk("srl8", o_result, {16{8'h01}});
        take();

        run_op(3'd2, 6'b000000, 5'd3, {4{32'h1}}, {4{32'h1}}, {4{32'hAAAAAAAA}}, lat);
        chk("tail32", o_result, 128'hAAAAAAAA_00000002_00000002_00000002);
        take();
        run_op(3'd2, 6'b000000, 5'd0, {4{32'h1}}, {4{32'h1}}, {4{32'hAAAAAAAA}}, lat);
        chk("vl0_res", o_result, {4{32'hAAAAAAAA}});
        chk("vl0_lat", 128'(lat), 128'd0);
        chk("vl0_err", 128'(o_err), 128'd0);
        take();

        // vl beyond VLEN/SEW clamps to 2 at SEW=64: both elements are body elements.
        run_op(3'd3, 6'b000101, 5'd31, {64'hF0F0F0F0F0F0F0F0, 64'h1},
               {64'h0F0F0F0F0F0F0F0F, 64'h2}, {2{64'h5555555555555555}}, lat);
        chk("or64_clamp", o_result, {64'hFFFFFFFFFFFFFFFF, 64'h3});
        take();

        // Backpressure: result held, second request waits for the handshake.
        run_op(3'd0, 6'b000110, 5'd16, {16{8'h0F}}, {16{8'hFF}}, 128'd0, lat);
        drive(3'd3, 6'b000001, 5'd2, {64'd1, 64'd5}, {64'd2, 64'd3}, 128'd0);
        held = o_result;
        chk("bp_res0", held, {16{8'hF0}});
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            chk("bp_valid", 128'(o_valid), 128'd1);
            chk("bp_ready", 128'(o_ready), 128'd0);
            chk("bp_hold",  o_result, {16{8'hF0}});
        end
        @(negedge i_clk); i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_hs_valid", 128'(o_valid), 128'd0);
        chk("bp_hs_ready", 128'(o_ready), 128'd1);
        @(negedge i_clk); i_ready = 1'b0;
        @(posedge i_clk); #1; i_valid = 1'b0;
        wait_valid(lat);
        chk("bp_sub64", o_result, {64'hFFFFFFFFFFFFFFFF, 64'h2});
        chk("bp_lat", 128'(lat), 128'd2);
        take();

        run_op(3'd4, 6'b000000, 5'd16, {16{8'h11}}, {16{8'h22}}, {8{16'hBEEF}}, lat);
        chk("sew4_err", 128'(o_err), 128'd1);
        chk("sew4_res", o_result, {8{16'hBEEF}});
        chk("sew4_lat", 128'(lat), 128'd0);
        take();
        run_op(3'd0, 6'b000111, 5'd16, {16{8'h11}}, {16{8'h22}}, {4{32'h12345678}}, lat);
        chk("ctrl_err", 128'(o_err), 128'd1);
        chk("ctrl_res", o_result, {4{32'h12345678}});
        take();

        // Reset during RUN beat 0 (result register still holds the previous value).
        drive(3'd0, 6'b000000, 5'd16, {16{8'h01}}, {16{8'h01}}, 128'd0);
        @(posedge i_clk); #1; i_valid = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(o_valid), 128'd0);
        chk("mid_rst_res",   o_result,      128'd0);
        chk("mid_rst_ready", 128'(o_ready), 128'd1);
        @(negedge i_clk); i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("post_rst_valid", 128'(o_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
